// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier controller.
// Contents: FSM state encoding (3-bit) and the requester count.
// Used by mult_arb_ctrl and rr_arb2.
package mult_ctrl_pkg;

   localparam int STATE_W = 3;
   localparam int NREQ    = 2;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
   localparam logic [STATE_W-1:0] ST_CHECK = 3'd2;
   localparam logic [STATE_W-1:0] ST_SHIFT = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = ST_IDLE,
      S_LOAD  = ST_LOAD,
      S_CHECK = ST_CHECK,
      S_SHIFT = ST_SHIFT,
      S_DONE  = ST_DONE
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: combinational two-way arbiter, one-hot winner.
// Ports:   Req[1:0] requests, last = requester served most recently, win[1:0] one-hot.
// Config:  MULT_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties, last ignored).
module rr_arb2
   import mult_ctrl_pkg::*;
(
   input  logic [NREQ-1:0] Req,
   input  logic            last,
   output logic [NREQ-1:0] win
);

`ifdef MULT_FIXED_PRIO_EN
   // Requester 0 always wins a tie; last is ignored in this mode.
   logic unused_last;
   assign unused_last = last;
   assign win[0] = Req[0];
   assign win[1] = Req[1] & ~Req[0];
`else
   // On a tie the requester that was not served last wins.
   assign win[0] = Req[0] & (~Req[1] |  last);
   assign win[1] = Req[1] & (~Req[0] | ~last);
`endif

endmodule

// File: rtl/mult_arb_ctrl.sv
// Purpose: arbitrates two requesters onto one N-bit shift-add multiplier and sequences it
//          (Load, then N steps of optional Ad followed by Sh), with an internal bit counter.
// Ports:   Clk, Rst (async active-low), Req[1:0] level requests, M multiplier LSB;
//          Gnt[1:0] registered one-hot grant / operand select, Load/Ad/Sh datapath controls,
//          Done[1:0] one-cycle completion pulse to the granted requester, Idle.
// Config:  MULT_FIXED_PRIO_EN -> fixed priority (requester 0 wins ties, no last register);
//          undefined -> round-robin between the two requesters.
module mult_arb_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter int N = 8
)
(
   input  logic            Clk,
   input  logic            Rst,
   input  logic [NREQ-1:0] Req,
   input  logic            M,
   output logic [NREQ-1:0] Gnt,
   output logic            Load,
   output logic            Ad,
   output logic            Sh,
   output logic [NREQ-1:0] Done,
   output logic            Idle
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] win;
   logic            last_q;
   logic            last_step;

`ifndef MULT_FIXED_PRIO_EN
   logic            last_d;
`endif

`ifdef MULT_FIXED_PRIO_EN
   // No history kept; the arbiter ignores this input in fixed-priority mode.
   assign last_q = 1'b1;
`endif

   rr_arb2 u_arb (
      .Req  (Req),
      .last (last_q),
      .win  (win)
   );

   assign last_step = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
`ifndef MULT_FIXED_PRIO_EN
      last_d  = last_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (Req != '0) begin
               gnt_d   = win;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d   = '0;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (M) begin
               state_d = S_SHIFT;
            end else if (last_step) begin
               // Counter holds on the final step so it never wraps.
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SHIFT: begin
            if (last_step) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = S_CHECK;
            end
         end
         S_DONE: begin
`ifndef MULT_FIXED_PRIO_EN
            last_d  = gnt_q[1];
`endif
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         gnt_q   <= '0;
`ifndef MULT_FIXED_PRIO_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
`ifndef MULT_FIXED_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

   // Everything except Gnt decodes from state so reset clears it immediately.
   assign Gnt  = gnt_q;
   assign Idle = (state_q == S_IDLE);
   assign Load = (state_q == S_LOAD);
   assign Ad   = (state_q == S_CHECK) &  M;
   assign Sh   = ((state_q == S_CHECK) & ~M) | (state_q == S_SHIFT);
   assign Done = (state_q == S_DONE) ? gnt_q : '0;

endmodule
